// File: rtl/paq_pkg.sv
// rtl/paq_pkg.sv - shared constants and slot addressing for the 2-bit to 8-bit packer
package paq_pkg;

    localparam int SYM_W  = 2;
    localparam int N_SYM  = 4;
    localparam int WORD_W = SYM_W * N_SYM;
    localparam int CNT_W  = $clog2(N_SYM);

    // Bit offset of symbol slot cnt; MSB-first mirrors the slot order.
    function automatic int slot_lo(input int cnt, input bit lsb_first,
                                   input int sym_w = SYM_W, input int n_sym = N_SYM);
        return lsb_first ? cnt * sym_w : (n_sym - 1 - cnt) * sym_w;
    endfunction

endpackage

// File: rtl/paq_reg_salida.sv
// rtl/paq_reg_salida.sv - valid/ready output holding register for packed words
module paq_reg_salida #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [WORD_W-1:0] data_out,
    output logic              busy
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = word;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign busy      = valid_q && !ready_in;

endmodule

// File: rtl/paq_2b_a_8b.sv
// rtl/paq_2b_a_8b.sv - packs consecutive narrow symbols into a word with valid/ready output
module paq_2b_a_8b #(
    parameter int SYM_W     = paq_pkg::SYM_W,
    parameter int N_SYM     = paq_pkg::N_SYM,
    parameter int LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   valid_in,
    input  logic [SYM_W-1:0]       data_in,
    output logic                   ready_out,
    output logic                   valid_out,
    output logic [SYM_W*N_SYM-1:0] data_out,
    input  logic                   ready_in
);
    import paq_pkg::*;

    localparam int W_W = SYM_W * N_SYM;
    localparam int C_W = $clog2(N_SYM);
    localparam logic [C_W-1:0] LAST = C_W'(N_SYM - 1);

    logic [C_W-1:0] cnt_q, cnt_d;
    logic [W_W-1:0] partial_q, partial_d;
    logic [W_W-1:0] merged;
    logic           busy;
    logic           accept;
    logic           load;

    // Only a completing accept writes the output register, so only it must wait.
    assign ready_out = !(cnt_q == LAST && busy);
    assign accept    = valid_in && ready_out;
    assign load      = accept && (cnt_q == LAST);

    always_comb begin
        merged = partial_q;
        merged[slot_lo(int'(cnt_q), LSB_FIRST != 0, SYM_W, N_SYM) +: SYM_W] = data_in;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        if (accept) begin
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                partial_d = '0;
            end else begin
                cnt_d     = cnt_q + C_W'(1);
                partial_d = merged;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            cnt_q     <= '0;
            partial_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

    paq_reg_salida #(
        .WORD_W(W_W)
    ) u_reg_salida (
        .clk      (clk),
        .reset_L  (reset_L),
        .load     (load),
        .word     (merged),
        .ready_in (ready_in),
        .valid_out(valid_out),
        .data_out (data_out),
        .busy     (busy)
    );

endmodule

// File: tb/tb_paq_2b_a_8b.sv
// tb/tb_paq_2b_a_8b.sv - scoreboard bench for the symbol packer in both slot orders
module tb_paq_2b_a_8b;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       valid_in;
    logic [1:0] data_in;
    logic       ready_in;
    logic       ready_out0, valid_out0, ready_out1, valid_out1;
    logic [7:0] data_out0, data_out1;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];
    logic [1:0] syms[$];

    always #5 clk = ~clk;

    paq_2b_a_8b #(.SYM_W(2), .N_SYM(4), .LSB_FIRST(1)) dut0 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out0), .valid_out(valid_out0), .data_out(data_out0), .ready_in(ready_in)
    );

    paq_2b_a_8b #(.SYM_W(2), .N_SYM(4), .LSB_FIRST(0)) dut1 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out1), .valid_out(valid_out1), .data_out(data_out1), .ready_in(ready_in)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [1:0] s);
        logic [7:0] wl, wm;
        syms.push_back(s);
        if (syms.size() == 4) begin
            wl = '0;
            wm = '0;
            for (int i = 0; i < 4; i++) begin
                wl[i*2 +: 2]     = syms[i];
                wm[(3-i)*2 +: 2] = syms[i];
            end
            q_lsb.push_back(wl);
            q_msb.push_back(wm);
            syms.delete();
        end
    endtask

    // Offer one symbol until accepted; returns just after the accepting edge with valid_in still high.
    task automatic put(input logic [1:0] s);
        bit done = 0;
        valid_in = 1'b1;
        data_in  = s;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (ready_out0) done = 1;
            @(posedge clk);
            #1;
        end
        if (done) model_accept(s);
        else chk("put_timeout", 8'h00, 8'h01);
    endtask

    task automatic idle();
        valid_in = 1'b0;
        data_in  = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset_L && valid_out0 && ready_in) begin
            if (q_lsb.size() == 0) chk("spurious_word_lsb", data_out0, 8'hxx);
            else chk("word_lsb", data_out0, q_lsb.pop_front());
        end
        if (!reset_L && valid_out1 && ready_in) begin
            if (q_msb.size() == 0) chk("spurious_word_msb", data_out1, 8'hxx);
            else chk("word_msb", data_out1, q_msb.pop_front());
        end
    end

    initial begin
        reset_L  = 1'b1;
        valid_in = 1'b0;
        data_in  = 2'd0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", {7'd0, valid_out0}, 8'h00);
        chk("rst_data_out", data_out0, 8'h00);
        chk("rst_ready_out", {7'd0, ready_out0}, 8'h01);
        chk("rst_data_out_msb", data_out1, 8'h00);
        @(posedge clk);
        #1;
        reset_L = 1'b0;

        // Leave a word pending plus a partial one, then reset asynchronously.
        ready_in = 1'b0;
        put(2'd1); put(2'd1); put(2'd1); put(2'd1);
        put(2'd3); put(2'd3);
        valid_in = 1'b0;
        @(negedge clk);
        chk("pending_before_rst", data_out0, 8'h55);
        #2;
        reset_L = 1'b1;
        #1;
        chk("async_rst_valid", {7'd0, valid_out0}, 8'h00);
        chk("async_rst_data", data_out0, 8'h00);
        q_lsb.delete();
        q_msb.delete();
        syms.delete();
        @(posedge clk);
        #1;
        reset_L  = 1'b0;
        ready_in = 1'b1;

        // Fresh word after reset, one-cycle valid pulse.
        put(2'd1); put(2'd2); put(2'd3); put(2'd0);
        valid_in = 1'b0;
        @(negedge clk);
        chk("stream_valid", {7'd0, valid_out0}, 8'h01);
        chk("stream_data", data_out0, 8'h39);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stream_valid_drop", {7'd0, valid_out0}, 8'h00);
        chk("stream_data_kept", data_out0, 8'h39);
        @(posedge clk);
        #1;

        // Backpressure with 8'h39 pending, then handoff coinciding with completion.
        ready_in = 1'b0;
        put(2'd1); put(2'd2); put(2'd3); put(2'd0);
        put(2'd3); put(2'd3); put(2'd3);
        valid_in = 1'b1;
        data_in  = 2'd3;
        repeat (2) begin
            @(negedge clk);
            chk("bp_ready_low", {7'd0, ready_out0}, 8'h00);
            chk("bp_hold_data", data_out0, 8'h39);
            chk("bp_hold_valid", {7'd0, valid_out0}, 8'h01);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("handoff_ready", {7'd0, ready_out0}, 8'h01);
        @(posedge clk);
        #1;
        model_accept(2'd3);
        valid_in = 1'b0;
        @(negedge clk);
        chk("no_bubble_valid", {7'd0, valid_out0}, 8'h01);
        chk("no_bubble_data", data_out0, 8'hFF);
        @(posedge clk);
        #1;

        // Gapped input: idle cycles must not advance the slot counter.
        put(2'd2); idle(); put(2'd2); idle(); put(2'd2); idle(); put(2'd2);
        valid_in = 1'b0;
        @(negedge clk);
        chk("gap_data", data_out0, 8'hAA);
        @(posedge clk);
        #1;

        // MSB-first ordering on the mirrored instance.
        put(2'd1); put(2'd2); put(2'd3); put(2'd0);
        valid_in = 1'b0;
        @(negedge clk);
        chk("msb_first_data", data_out1, 8'h6C);
        chk("lsb_first_data", data_out0, 8'h39);
        repeat (3) @(posedge clk);
        #1;
        chk("q_lsb_drained", 8'(q_lsb.size()), 8'h00);
        chk("q_msb_drained", 8'(q_msb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
